npu_result_drain: RTL and testbench
===================================

# npu_result_drain

Downstream stage of the systolic-array tile: accepts 48-bit result vectors (3 lanes × 16-bit signed partial sums) from the array output and post-processes each lane with an arithmetic right-shift, optional ReLU, and saturation to 8 bits. Packed 24-bit results are buffered in a FIFO that the Caravel management core drains over Wishbone. Sits between the array's `out` bus and the Wishbone interconnect, at its own base address next to the image/weight RAM window.

## Interface
- `LANES`, 3, result lanes per vector
- `LANE_W`, 16, signed width of each lane
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `BASE_ADDRESS`, 24'h3000_01, matched against `adr[31:8]`

- `caravel_wb_clk_i` in 1: single clock for the block.
- `caravel_wb_rst_ni` in 1: one clock; reset is asynchronous and active-low.
- `res_valid_i` in 1: result vector valid.
- `res_data_i` in LANES*LANE_W: lane k at `[16k+15:16k]`.
- `res_ready_o` out 1: block can accept a vector this cycle.
- `caravel_wb_stb_i`, `caravel_wb_cyc_i`, `caravel_wb_we_i` in 1 each: Wishbone strobe, cycle and write enable.
- `caravel_wb_sel_i` in 4: byte select; ignored, full-word access only.
- `caravel_wb_dat_i` in 32: write data.
- `caravel_wb_adr_i` in 32: address.
- `caravel_wb_ack_o` out 1: ack.
- `caravel_wb_dat_o` out 32: read data.

## Operation
- Handshake: a transfer occurs when `res_valid_i & res_ready_o`. `res_ready_o = (count + s1_valid) < DEPTH`. With `clear` active it is forced to 0.
- Stage 1 register, per lane:
  - `y = x >>> CTRL.shift`.
  - If `CTRL.relu` and `y < 0`, then `y = 0`.
  - Saturate to signed 8-bit: `>127 → 127`, `<-128 → -128`.
  - Pack lane k into `[8k+7:8k]`.
- Stage 2: the stage-1 result is written into the FIFO.
- Wishbone select is `adr[31:8] == BASE_ADDRESS & cyc & stb`. Word offset is `adr[3:2]`.
  - 0 STATUS, read:
    - `[3:0]` count
    - `[4]` empty
    - `[5]` full
    - `[6]` underflow, sticky
    - `[7]` input_stall, sticky; set on any cycle with `res_valid_i & ~res_ready_o`
  - STATUS write: W1C on bits 6 and 7.
  - 1 DATA, read: `{8'h0, head}` and pops. When empty it returns 0, does not pop, and sets underflow. Writes are ignored.
  - 2 CTRL, R/W:
    - `[3:0]` shift
    - `[4]` relu
    - `[11:8]` irq_level
    - `[16]` clear: write-1, self-clearing, reads 0
  - 3: reads 0, writes ignored.
- Clear flushes the FIFO and stage 1 and clears the sticky bits. CTRL fields are kept.
- Simultaneous push and pop leave count unchanged. A pop of the last entry with a simultaneous push gives count 1.
- Read/write pointers are log2(DEPTH) bits and wrap naturally. The full/empty distinction comes from a separate count register of width log2(DEPTH)+1.

## Timing
- Ack: registered. It rises one cycle after a selected `cyc&stb` and lasts exactly one cycle. It cannot re-assert on the cycle after ack.
- Register side effects (pop, clear, W1C) happen on the ack cycle. Read data is valid while ack is high.
- Latency: a vector accepted at edge N is in stage 1 at N+1, in the FIFO at N+2, and visible in STATUS.count from cycle N+2.
- Reset values:
  - ack=0, dat_o=0, res_ready_o=0 while in reset, then 1 on the first cycle after release.
  - count=0, pointers=0, stage-1 valid=0.
  - CTRL shift=0, relu=1, irq_level=DEPTH-1.
  - Sticky bits 0.
- Reset asserted mid-operation clears everything asynchronously. A pending ack is dropped, and the Wishbone master times out or retries.

## Configuration
- `NPU_DRAIN_IRQ_EN` defined: adds output `irq_o`. It is registered: 1 when `count >= CTRL.irq_level` or a sticky bit is set. Its reset value is 0.
- `NPU_DRAIN_IRQ_EN` undefined: no `irq_o` port. `CTRL[11:8]` reads 0 and writes to it are ignored.

## Structure
- Shared package `npu_pkg` holds:
  - `LANES` and `LANE_W`
  - register offsets `REG_STATUS`, `REG_DATA`, `REG_CTRL`
  - CTRL and STATUS bit-position constants
  - the packed-result typedef
- Sub-module `npu_sync_fifo` (parameters DWIDTH, DEPTH) provides push/pop, count, full and empty.
- Post-processing and the Wishbone decode stay in the top module.

## Test plan
- Reset, then read STATUS: 0x10 (empty). Read CTRL: 0x0000_0710 with DEPTH=8. `res_ready_o`=1.
- Push lanes {0x0100, 0xFF00, 0x7FFF} with shift=4 and relu=1, then read DATA: 0x007F_0010. Lane 1 clamps to 0 and lane 2 saturates to 127.
- Same push with relu=0 and shift=8: DATA = 0x007F_FF01.
- Push 9 vectors back-to-back with no reads:
  - `res_ready_o` drops after 8 are accepted.
  - STATUS = 0xA8: count 8, full, stall.
  - 8 DATA reads return push order.
  - A 9th read returns 0, and STATUS = 0xD0 (empty, underflow, stall).
- Push and a DATA read in the same cycle at count 3: count stays 3 and the FIFO order is preserved. Write CTRL clear: STATUS = 0x10 on the next read.
- Assert reset during an un-acked Wishbone read with count 5: no ack, and after release STATUS = 0x10.

Source files
------------

// File: rtl/npu_pkg.sv
// npu_pkg: constants and types shared by the result-drain block and its FIFO.
package npu_pkg;

  localparam int LANES  = 3;
  localparam int LANE_W = 16;
  localparam int OUT_W  = 8;

  // Wishbone word offsets (adr[3:2])
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // STATUS bit positions
  localparam int ST_COUNT_LSB = 0;
  localparam int ST_EMPTY     = 4;
  localparam int ST_FULL      = 5;
  localparam int ST_UFLOW     = 6;
  localparam int ST_STALL     = 7;

  // CTRL bit positions
  localparam int CTRL_SHIFT_LSB = 0;
  localparam int CTRL_RELU      = 4;
  localparam int CTRL_IRQ_LSB   = 8;
  localparam int CTRL_CLEAR     = 16;

  // One packed result: lane k occupies [8k+7:8k]
  typedef logic [LANES*OUT_W-1:0] packed_res_t;

endpackage

// File: rtl/npu_sync_fifo.sv
// npu_sync_fifo: single-clock FIFO with natural-wrap pointers and a separate
// occupancy counter that distinguishes full from empty. Push while full and
// pop while empty are ignored; a synchronous clear flushes the contents.
module npu_sync_fifo #(
  parameter int DWIDTH = 24,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DWIDTH-1:0]        wdata,
  output logic [DWIDTH-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array: written on accepted pushes only, never reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/npu_result_drain.sv
// npu_result_drain: takes 3-lane int16 result vectors from the systolic array,
// applies arithmetic right shift, optional ReLU and int8 saturation, and queues
// the packed 24-bit words for the management core to read over Wishbone.
// Optional build macro NPU_DRAIN_IRQ_EN adds the registered irq_o output and
// the CTRL irq_level field.
module npu_result_drain
  import npu_pkg::*;
#(
  parameter int          DEPTH        = 8,
  parameter logic [23:0] BASE_ADDRESS = 24'h3000_01
) (
  input  logic                    caravel_wb_clk_i,
  input  logic                    caravel_wb_rst_ni,
  input  logic                    res_valid_i,
  input  logic [LANES*LANE_W-1:0] res_data_i,
  output logic                    res_ready_o,
  input  logic                    caravel_wb_stb_i,
  input  logic                    caravel_wb_cyc_i,
  input  logic                    caravel_wb_we_i,
  input  logic [3:0]              caravel_wb_sel_i,
  input  logic [31:0]             caravel_wb_dat_i,
  input  logic [31:0]             caravel_wb_adr_i,
  output logic                    caravel_wb_ack_o,
  output logic [31:0]             caravel_wb_dat_o
`ifdef NPU_DRAIN_IRQ_EN
  ,
  output logic                    irq_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic signed [LANE_W-1:0] SAT_HI = LANE_W'(127);
  localparam logic signed [LANE_W-1:0] SAT_LO = LANE_W'(-128);

  // Saturate a wide signed value into the int8 range
  function automatic logic signed [OUT_W-1:0] sat_int8(input logic signed [LANE_W-1:0] v);
    logic signed [OUT_W-1:0] r;
    if (v > SAT_HI)      r = 8'sh7f;
    else if (v < SAT_LO) r = 8'sh80;
    else                 r = v[OUT_W-1:0];
    return r;
  endfunction

  // Clamp negatives to zero when ReLU is enabled
  function automatic logic signed [LANE_W-1:0] relu_clip(input logic signed [LANE_W-1:0] v,
                                                         input logic en);
    return (en && v[LANE_W-1]) ? '0 : v;
  endfunction

  // Full per-lane post-processing: shift, ReLU, saturate
  function automatic logic [OUT_W-1:0] post_lane(input logic signed [LANE_W-1:0] x,
                                                 input logic [3:0] sh,
                                                 input logic relu);
    return sat_int8(relu_clip(x >>> sh, relu));
  endfunction

  logic              clk;
  logic              rst_n;
  logic              wb_hit;
  logic [1:0]        reg_off;
  logic              wr_acc;
  logic              rd_acc;
  logic              ctrl_wr;
  logic              w1c_wr;
  logic              data_rd;
  logic              clear_req;
  logic              pop;
  logic              uflow_set;
  logic              stall_set;
  logic              accept;
  logic [3:0]        ctrl_shift;
  logic              ctrl_relu;
  logic              sticky_uflow;
  logic              sticky_stall;
  packed_res_t       proc_p0;
  packed_res_t       data_p1;
  logic              vld_p1;
  packed_res_t       fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       rd_word;
  logic              unused_bits;

  assign clk   = caravel_wb_clk_i;
  assign rst_n = caravel_wb_rst_ni;

  assign wb_hit    = caravel_wb_cyc_i & caravel_wb_stb_i &
                     (caravel_wb_adr_i[31:8] == BASE_ADDRESS);
  assign reg_off   = caravel_wb_adr_i[3:2];
  assign wr_acc    = caravel_wb_ack_o & caravel_wb_we_i;
  assign rd_acc    = caravel_wb_ack_o & ~caravel_wb_we_i;
  assign ctrl_wr   = wr_acc & (reg_off == REG_CTRL);
  assign w1c_wr    = wr_acc & (reg_off == REG_STATUS);
  assign data_rd   = rd_acc & (reg_off == REG_DATA);
  assign clear_req = ctrl_wr & caravel_wb_dat_i[CTRL_CLEAR];
  assign pop       = data_rd & ~fifo_empty;
  assign uflow_set = data_rd & fifo_empty;

  // Room is counted including the vector already in stage 1
  assign res_ready_o = rst_n & ~clear_req &
                       ((32'(fifo_count) + 32'(vld_p1)) < 32'(DEPTH));
  assign accept      = res_valid_i & res_ready_o;
  assign stall_set   = res_valid_i & ~res_ready_o;

  assign unused_bits = ^{caravel_wb_sel_i, caravel_wb_dat_i,
                         caravel_wb_adr_i[7:4], caravel_wb_adr_i[1:0]};

  // Per-lane post-processing of the incoming vector
  always_comb begin
    proc_p0 = '0;
    for (int k = 0; k < LANES; k++) begin
      proc_p0[k*OUT_W +: OUT_W] = post_lane($signed(res_data_i[k*LANE_W +: LANE_W]),
                                            ctrl_shift, ctrl_relu);
    end
  end

  // ---- stage 1: processed vector register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= accept;
  end

  // Stage 1 payload follows the handshake only
  always_ff @(posedge clk) begin
    if (accept) data_p1 <= proc_p0;
  end

  // ---- stage 2: FIFO write ----
  npu_sync_fifo #(
    .DWIDTH (LANES*OUT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_req),
    .push  (vld_p1),
    .pop   (pop),
    .wdata (data_p1),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Wishbone ack: one-cycle pulse, never on the cycle right after an ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) caravel_wb_ack_o <= 1'b0;
    else        caravel_wb_ack_o <= wb_hit & ~caravel_wb_ack_o;
  end

  // CTRL shift/relu; preserved across clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_shift <= 4'd0;
      ctrl_relu  <= 1'b1;
    end else if (ctrl_wr) begin
      ctrl_shift <= caravel_wb_dat_i[CTRL_SHIFT_LSB +: 4];
      ctrl_relu  <= caravel_wb_dat_i[CTRL_RELU];
    end
  end

  // Sticky error flags: set by events, W1C via STATUS, wiped by clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_uflow <= 1'b0;
      sticky_stall <= 1'b0;
    end else if (clear_req) begin
      sticky_uflow <= 1'b0;
      sticky_stall <= 1'b0;
    end else begin
      sticky_uflow <= (sticky_uflow & ~(w1c_wr & caravel_wb_dat_i[ST_UFLOW])) | uflow_set;
      sticky_stall <= (sticky_stall & ~(w1c_wr & caravel_wb_dat_i[ST_STALL])) | stall_set;
    end
  end

`ifdef NPU_DRAIN_IRQ_EN
  logic [3:0] ctrl_irq_level;

  // CTRL irq threshold; preserved across clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ctrl_irq_level <= 4'(DEPTH - 1);
    else if (ctrl_wr) ctrl_irq_level <= caravel_wb_dat_i[CTRL_IRQ_LSB +: 4];
  end

  // Interrupt: fill level reached or any sticky error pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_o <= 1'b0;
    else        irq_o <= (32'(fifo_count) >= 32'(ctrl_irq_level)) | sticky_uflow | sticky_stall;
  end
`endif

  // Register read mux; DATA reads of an empty FIFO return zero
  always_comb begin
    rd_word = '0;
    case (reg_off)
      REG_STATUS: begin
        rd_word[ST_COUNT_LSB +: 4] = 4'(fifo_count);
        rd_word[ST_EMPTY]          = fifo_empty;
        rd_word[ST_FULL]           = fifo_full;
        rd_word[ST_UFLOW]          = sticky_uflow;
        rd_word[ST_STALL]          = sticky_stall;
      end
      REG_DATA: begin
        if (!fifo_empty) rd_word[LANES*OUT_W-1:0] = fifo_head;
      end
      REG_CTRL: begin
        rd_word[CTRL_SHIFT_LSB +: 4] = ctrl_shift;
        rd_word[CTRL_RELU]           = ctrl_relu;
`ifdef NPU_DRAIN_IRQ_EN
        rd_word[CTRL_IRQ_LSB +: 4]   = ctrl_irq_level;
`endif
      end
      default: rd_word = '0;
    endcase
  end

  assign caravel_wb_dat_o = rd_acc ? rd_word : 32'h0;

endmodule

// File: tb/tb_npu_result_drain.sv
// tb_npu_result_drain: table-driven lane-processing vectors, hand-written
// multi-cycle sequences (fill/stall, concurrent push+pop, clear, reset during
// a pending read) and a randomized phase checked against a queue-based model.
module tb_npu_result_drain;

  localparam logic [31:0] BASE = 32'h3000_0100;
`ifdef NPU_DRAIN_IRQ_EN
  localparam logic [31:0] IRQ_RD = 32'h0000_0700;
`else
  localparam logic [31:0] IRQ_RD = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        res_valid = 1'b0;
  logic [47:0] res_data = '0;
  logic        res_ready;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] wdat = '0;
  logic [31:0] adr = '0;
  logic        ack;
  logic [31:0] rdat;
`ifdef NPU_DRAIN_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad   = 0;

  npu_result_drain dut (
    .caravel_wb_clk_i  (clk),
    .caravel_wb_rst_ni (rst_n),
    .res_valid_i       (res_valid),
    .res_data_i        (res_data),
    .res_ready_o       (res_ready),
    .caravel_wb_stb_i  (stb),
    .caravel_wb_cyc_i  (cyc),
    .caravel_wb_we_i   (we),
    .caravel_wb_sel_i  (sel),
    .caravel_wb_dat_i  (wdat),
    .caravel_wb_adr_i  (adr),
    .caravel_wb_ack_o  (ack),
    .caravel_wb_dat_o  (rdat)
`ifdef NPU_DRAIN_IRQ_EN
    ,
    .irq_o             (irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // One Wishbone access; called #1 after a rising edge, returns #1 after the
  // edge that applies the side effects.
  task automatic wb_xfer(input logic wr, input logic [1:0] off, input logic [31:0] d,
                         output logic [31:0] r);
    int n;
    adr = BASE | (32'(off) << 2);
    we = wr; wdat = d; cyc = 1'b1; stb = 1'b1;
    n = 0; r = '0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 10);
    if (!ack) begin
      total++; bad++;
      $display("FAIL wb_timeout: got no ack expected ack within 10 cycles");
    end else begin
      r = rdat;
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic wb_rd(input logic [1:0] off, output logic [31:0] r);
    wb_xfer(1'b0, off, 32'h0, r);
  endtask

  task automatic wb_wr(input logic [1:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, off, d, dummy);
  endtask

  // Offer one vector and hold it until accepted (bounded)
  task automatic push_vec(input logic [47:0] d);
    int n;
    res_valid = 1'b1; res_data = d; n = 0;
    forever begin
      @(negedge clk);
      if (res_ready) break;
      n++;
      if (n > 20) break;
    end
    if (n > 20) begin
      total++; bad++;
      $display("FAIL push_timeout: got ready=0 expected ready=1 within 20 cycles");
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  function automatic logic [31:0] ctrl_word(input logic [3:0] sh, input logic relu, input logic clr);
    return {15'b0, clr, 4'h0, 4'h7, 3'b0, relu, sh};
  endfunction

  function automatic logic [47:0] fill_vec(input int i);
    logic [15:0] a, b, c;
    a = 16'(i + 1); b = 16'(i + 16); c = 16'(-(i + 1));
    return {c, b, a};
  endfunction

  function automatic logic [31:0] fill_exp(input int i);
    return {8'h00, 8'(-(i + 1)), 8'(i + 16), 8'(i + 1)};
  endfunction

  // Reference lane: real-valued floor division, then clamps
  function automatic logic [7:0] ref_lane(input logic signed [15:0] x, input int sh, input bit relu);
    int xi, y;
    xi = x;
    y = int'($floor(real'(xi) / (2.0 ** sh)));
    if (relu && y < 0) y = 0;
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return 8'(y);
  endfunction

  function automatic logic [31:0] ref_vec(input logic [47:0] d, input int sh, input bit relu);
    return {8'h00, ref_lane(d[47:32], sh, relu), ref_lane(d[31:16], sh, relu),
            ref_lane(d[15:0], sh, relu)};
  endfunction

  typedef struct {
    logic [15:0] l0, l1, l2;
    logic [3:0]  sh;
    logic        relu;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [9];

  logic [31:0] rd;
  logic        rdy;
  int          accepted;
  logic [31:0] mq [$];
  logic        m_uflow;

  initial begin
    tbl[0] = '{16'h0100, 16'hFF00, 16'h7FFF, 4'd4,  1'b1, 32'h007F_0010};
    tbl[1] = '{16'h0100, 16'hFF00, 16'h7FFF, 4'd8,  1'b0, 32'h007F_FF01};
    tbl[2] = '{16'h0000, 16'h0000, 16'h0000, 4'd0,  1'b0, 32'h0000_0000};
    tbl[3] = '{16'h007F, 16'h0080, 16'hFF80, 4'd0,  1'b0, 32'h0080_7F7F};
    tbl[4] = '{16'hFF7F, 16'h8000, 16'h0001, 4'd0,  1'b0, 32'h0001_8080};
    tbl[5] = '{16'hFF7F, 16'h8000, 16'h0001, 4'd0,  1'b1, 32'h0001_0000};
    tbl[6] = '{16'h8000, 16'h7FFF, 16'hFFFF, 4'd15, 1'b0, 32'h00FF_00FF};
    tbl[7] = '{16'h0800, 16'hF800, 16'h0FF0, 4'd4,  1'b0, 32'h007F_807F};
    tbl[8] = '{16'hFFF1, 16'h0003, 16'h00FE, 4'd1,  1'b0, 32'h007F_01F8};

    // Reset behaviour
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, res_ready}, 32'h0);
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_dat", rdat, 32'h0);
`ifdef NPU_DRAIN_IRQ_EN
    check("rst_irq", {31'b0, irq}, 32'h0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", {31'b0, res_ready}, 32'h1);
    wb_rd(2'd0, rd); check("status_rst", rd, 32'h10);
    wb_rd(2'd2, rd); check("ctrl_rst", rd, 32'h10 | IRQ_RD);

    // Table-driven lane processing
    for (int i = 0; i < 9; i++) begin
      wb_wr(2'd2, ctrl_word(tbl[i].sh, tbl[i].relu, 1'b0));
      push_vec({tbl[i].l2, tbl[i].l1, tbl[i].l0});
      repeat (2) @(posedge clk);
      #1;
      wb_rd(2'd1, rd);
      check($sformatf("tbl%0d_data", i), rd, tbl[i].exp);
    end

    // Latency: not yet counted in the cycle after the handshake, counted one later
    wb_wr(2'd2, ctrl_word(4'd0, 1'b0, 1'b0));
    res_valid = 1'b1; res_data = fill_vec(30);
    fork
      begin @(posedge clk); #1; res_valid = 1'b0; end
      begin wb_rd(2'd0, rd); end
    join
    check("lat_stage1", rd, 32'h10);
    wb_rd(2'd1, rd); check("lat_drain1", rd, fill_exp(30));
    res_valid = 1'b1; res_data = fill_vec(31);
    fork
      begin @(posedge clk); #1; res_valid = 1'b0; end
      begin @(posedge clk); #1; wb_rd(2'd0, rd); end
    join
    check("lat_fifo", rd, 32'h01);
    wb_rd(2'd1, rd); check("lat_drain2", rd, fill_exp(31));

    // Fill past capacity with no reads
    accepted = 0; rdy = 1'b1;
    res_valid = 1'b1; res_data = fill_vec(0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      rdy = res_ready;
      @(posedge clk); #1;
      if (rdy) begin
        accepted++;
        res_data = fill_vec(accepted);
      end
    end
    res_valid = 1'b0;
    check("fill_accepted", 32'(accepted), 32'd8);
    check("fill_ready_low", {31'b0, rdy}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    wb_rd(2'd0, rd); check("status_full", rd, 32'hA8);
`ifdef NPU_DRAIN_IRQ_EN
    check("irq_full", {31'b0, irq}, 32'h1);
`endif
    for (int i = 0; i < 8; i++) begin
      wb_rd(2'd1, rd);
      check($sformatf("fill_rd%0d", i), rd, fill_exp(i));
    end
    wb_rd(2'd1, rd); check("underflow_data", rd, 32'h0);
    wb_rd(2'd0, rd); check("status_uflow", rd, 32'hD0);
    wb_wr(2'd0, 32'hC0);
    wb_rd(2'd0, rd); check("status_w1c", rd, 32'h10);

    // Push and pop land on the same edge at count 3
    for (int i = 0; i < 3; i++) push_vec(fill_vec(20 + i));
    repeat (2) @(posedge clk);
    #1;
    wb_rd(2'd0, rd); check("conc_pre_count", rd, 32'h03);
    res_valid = 1'b1; res_data = fill_vec(23);
    adr = BASE | 32'h4; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("conc_ack", {31'b0, ack}, 32'h1);
    check("conc_data", rdat, fill_exp(20));
    res_valid = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    wb_rd(2'd0, rd); check("conc_post_count", rd, 32'h03);
    for (int i = 1; i < 4; i++) begin
      wb_rd(2'd1, rd);
      check($sformatf("conc_rd%0d", i), rd, fill_exp(20 + i));
    end

    // Clear flushes FIFO and sticky bits but keeps CTRL
    wb_rd(2'd1, rd); check("pre_clear_uflow_data", rd, 32'h0);
    push_vec(fill_vec(5));
    push_vec(fill_vec(6));
    wb_wr(2'd2, ctrl_word(4'd3, 1'b0, 1'b1));
    wb_rd(2'd0, rd); check("status_clear", rd, 32'h10);
    wb_rd(2'd2, rd); check("ctrl_kept", rd, 32'h03 | IRQ_RD);
    check("ready_after_clear", {31'b0, res_ready}, 32'h1);

    // Reset asserted during an un-acked read with five entries queued
    wb_wr(2'd2, ctrl_word(4'd0, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) push_vec(fill_vec(i));
    repeat (2) @(posedge clk);
    #1;
    wb_rd(2'd0, rd); check("status_five", rd, 32'h05);
    adr = BASE; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ack", {31'b0, ack}, 32'h0);
    check("midrst_ready", {31'b0, res_ready}, 32'h0);
    @(posedge clk); #1;
    check("midrst_ack_edge", {31'b0, ack}, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wb_rd(2'd0, rd); check("status_after_midrst", rd, 32'h10);
    wb_rd(2'd2, rd); check("ctrl_after_midrst", rd, 32'h10 | IRQ_RD);

    // Randomized batches against the queue model
    m_uflow = 1'b0;
    for (int b = 0; b < 8; b++) begin
      int sh, npush, nread;
      bit relu;
      logic [47:0] d;
      sh = $urandom_range(0, 15);
      relu = 1'($urandom_range(0, 1));
      wb_wr(2'd2, ctrl_word(4'(sh), relu, 1'b0));
      npush = $urandom_range(0, 8 - mq.size());
      for (int i = 0; i < npush; i++) begin
        d = {16'($urandom), 16'($urandom), 16'($urandom)};
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #0;
        push_vec(d);
        mq.push_back(ref_vec(d, sh, relu));
      end
      repeat (2) @(posedge clk);
      #1;
      wb_rd(2'd0, rd);
      check($sformatf("rnd%0d_status_push", b), rd,
            {24'h0, 1'b0, m_uflow, mq.size() == 8, mq.size() == 0, 4'(mq.size())});
      nread = $urandom_range(0, mq.size() + 1);
      for (int i = 0; i < nread; i++) begin
        logic [31:0] e;
        if (mq.size() == 0) begin
          e = 32'h0;
          m_uflow = 1'b1;
        end else begin
          e = mq.pop_front();
        end
        wb_rd(2'd1, rd);
        check($sformatf("rnd%0d_data%0d", b, i), rd, e);
      end
      wb_rd(2'd0, rd);
      check($sformatf("rnd%0d_status_pop", b), rd,
            {24'h0, 1'b0, m_uflow, mq.size() == 8, mq.size() == 0, 4'(mq.size())});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
